// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch control ahead of the settable PC register (request, hold, commit next PC).
// Optional macro FETCH_BRANCH_FLUSH_EN: a redirect during HOLD discards the held word and commits the target.
module fetch_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] pc,
  output logic             pcWriteEnable,
  output logic [WIDTH-1:0] pcNext,
  output logic             imemReq,
  output logic [WIDTH-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [WIDTH-1:0] imemRdata,
  output logic             instrValid,
  output logic [WIDTH-1:0] instr,
  input  logic             instrReady,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  output logic             fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    HOLD   = 3'd2,
    UPDATE = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [7:0]       count_reg, count_next, count_inc;
  logic             pend_reg, pend_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic [WIDTH-1:0] instr_reg, instr_next;
  logic             instr_valid_reg, instr_valid_next;
  logic             flush;

`ifdef FETCH_BRANCH_FLUSH_EN
  assign flush = (state_reg == HOLD) && branchTaken;
`else
  assign flush = 1'b0;
`endif

  assign count_inc = count_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= 8'd0;
      pend_reg        <= 1'b0;
      pend_target_reg <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      pend_reg        <= pend_next;
      pend_target_reg <= pend_target_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    pend_next        = pend_reg;
    pend_target_next = pend_target_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    pcWriteEnable    = 1'b0;
    pcNext           = '0;
    imemReq          = 1'b0;
    imemAddr         = '0;

    // Latest redirect wins; UPDATE below consumes and clears it.
    if (branchTaken && (state_reg != FAULT)) begin
      pend_next        = 1'b1;
      pend_target_next = branchTarget;
    end

    case (state_reg)
      IDLE: begin
        if (run) state_next = REQ;
      end
      REQ: begin
        imemReq  = 1'b1;
        imemAddr = pc;
        if (imemAck) begin
          instr_next       = imemRdata;
          instr_valid_next = 1'b1;
          count_next       = 8'd0;
          state_next       = HOLD;
        end else begin
          count_next = count_inc;
          if (count_inc == TIMEOUT_CNT) state_next = FAULT;
        end
      end
      HOLD: begin
        if (flush || (instr_valid_reg && instrReady)) begin
          instr_valid_next = 1'b0;
          state_next       = UPDATE;
        end
      end
      UPDATE: begin
        pcWriteEnable = 1'b1;
        if (branchTaken)   pcNext = branchTarget;
        else if (pend_reg) pcNext = pend_target_reg;
        else               pcNext = pc + WIDTH'(1);
        pend_next  = 1'b0;
        state_next = run ? REQ : IDLE;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign instrValid = instr_valid_reg;
  assign instr      = instr_reg;
  assign fault      = (state_reg == FAULT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch control stage that sits directly upstream of the enablable, settable program-counter register. It drives that register's `writeEnable` and `writeData` inputs and reads its `readData` output back as the current PC. Each fetch requests instruction memory at the current PC, holds the returned word for the decode stage under a valid/ready handshake, then commits the next PC (PC+1 or a pending branch target) with a one-cycle write pulse. A timeout counter flags a sticky fault if memory never acknowledges.

## Interface
Parameters:
- `WIDTH`, 8, PC, address and instruction width.
- `TIMEOUT`, 15, number of consecutive un-acknowledged request cycles that triggers a fault. Legal range 1 to 255.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `run`  input  1  fetch enable, level-sensitive.
- `pc`  input  WIDTH  current PC, from the PC register's `readData`.
- `pcWriteEnable`  output  1  to the PC register's `writeEnable`.
- `pcNext`  output  WIDTH  to the PC register's `writeData`.
- `imemReq`  output  1  instruction memory request.
- `imemAddr`  output  WIDTH  request address; equals `pc` while `imemReq`=1, otherwise 0.
- `imemAck`  input  1  memory acknowledge; `imemRdata` is valid in the same cycle.
- `imemRdata`  input  WIDTH  instruction word.
- `instrValid`  output  1  `instr` holds a fetched word.
- `instr`  output  WIDTH  held instruction.
- `instrReady`  input  1  downstream accepts `instr`.
- `branchTaken`  input  1  single-cycle redirect request.
- `branchTarget`  input  WIDTH  redirect address, sampled when `branchTaken`=1.
- `fault`  output  1  sticky memory-timeout flag.

## Operation
- Five states: IDLE, REQ, HOLD, UPDATE, FAULT.
- IDLE: all strobes low. Moves to REQ on the next edge when `run`=1.
- REQ: `imemReq`=1 and `imemAddr`=`pc`.
  - On `imemAck`=1: `instr` is captured from `imemRdata`, the timeout counter is cleared, and the state moves to HOLD.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, the state moves to FAULT.
- HOLD: `instrValid`=1 and `instr` is stable. When `instrValid` and `instrReady` are both 1, the state moves to UPDATE.
- UPDATE: `pcWriteEnable`=1 for exactly one cycle.
  - `pcNext` = pending target if a redirect is pending, otherwise `pc`+1.
  - The pending redirect is cleared.
  - Next state is REQ if `run`=1, else IDLE.
- FAULT: `fault`=1 and all other strobes are low. Only `reset` leaves FAULT.
- Redirect latch:
  - `branchTaken`=1 in any state except FAULT stores `branchTarget` and sets the pending flag.
  - A later `branchTaken` overwrites an earlier one.
  - If `branchTaken` arrives in the UPDATE cycle itself, it is used as `pcNext` directly and is not left pending.
  - A redirect never cancels a request that is already outstanding.
- Arithmetic: `pc`+1 is computed modulo 2^WIDTH, so all-ones wraps to 0.
- `run` deasserted in REQ or HOLD does not abort the fetch. The transaction completes through UPDATE, then the state goes to IDLE.

## Timing
- Reset values: state IDLE, counter 0, pending flag 0.
  - All outputs are 0: `pcWriteEnable`, `pcNext`, `imemReq`, `imemAddr`, `instrValid`, `instr`, `fault`.
- A reset asserted mid-operation takes effect at that edge; any outstanding request is dropped.
- `instr` and `instrValid` are registered. `imemReq`, `imemAddr`, `pcWriteEnable` and `pcNext` are decoded from the registered state.
- Minimum loop is 3 cycles per instruction (REQ, HOLD, UPDATE), reached when ack and ready are immediate.
- The PC register updates at the edge that ends UPDATE, so the following REQ presents the new PC.
- The fault asserts in the cycle after the `TIMEOUT`-th un-acked REQ cycle.

## Configuration
- `FETCH_BRANCH_FLUSH_EN` defined:
  - `branchTaken` during HOLD discards the held instruction: `instrValid` drops on the next edge.
  - The state jumps to UPDATE with `pcNext`=`branchTarget`, so the handshake is skipped.
  - `branchTaken` in any other state behaves as in Operation.
- `FETCH_BRANCH_FLUSH_EN` not defined: the held instruction is always delivered, and the target is applied at the next UPDATE.

## Test plan
- Reset, `pc`=1, `run`=1, `imemAck` and `instrReady` tied 1, `imemRdata`=0x3C:
  - `imemReq` is high with `imemAddr`=1, and `instr`=0x3C.
  - `pcWriteEnable` pulses with `pcNext`=2 in cycle 3 after reset release. The loop repeats every 3 cycles.
- `pc`=0xFF, one fetch: `pcNext`=0x00.
- `branchTaken`=1 with `branchTarget`=0x40 during REQ, flush macro undefined:
  - The current `instr` is still delivered.
  - UPDATE drives `pcNext`=0x40, and the next fetch uses 0x40.
- `imemAck` held 0 with `TIMEOUT`=15: `fault` rises after 15 REQ cycles and `imemReq` drops. `fault` stays high until `reset`.
- `instrReady` held 0 for 5 cycles in HOLD:
  - `instrValid` stays 1 and `instr` stays stable, with no `pcWriteEnable`.
  - Releasing ready gives UPDATE one cycle later.
- Flush macro defined, `branchTaken` with target 0x20 in HOLD: `instrValid` falls next cycle, then `pcWriteEnable`=1 with `pcNext`=0x20.
